// File: rtl/timer_entry_ctrl_pkg.sv
// timer_pkg: shared types and constants for the timer entry controller.
//   state_t          - controller states (IDLE, ENTRY, RUN, PAUSE)
//   digit_t          - one 4-bit BCD keypad/counter digit
//   TICK_DIV_DEFAULT - default clk cycles per countdown tick
//   is_digit()       - true for a decimal key (0..9)
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  typedef logic [3:0] digit_t;

  localparam int TICK_DIV_DEFAULT = 100;

  function automatic logic is_digit(input digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/timer_entry_ctrl_if.sv
// timer_entry_if: keypad/button inputs and downstream-counter controls of the
// timer entry controller.
//   master modport - environment side: drives keys, buttons and timer_zero
//   slave modport  - controller side: drives loadn, data_*, en, running,
//                    done and err
interface timer_entry_if;
  import timer_pkg::*;

  logic   digit_valid;
  digit_t digit;
  logic   startn;
  logic   stopn;
  logic   timer_zero;

  logic   loadn;
  digit_t data_min;
  digit_t data_sec_tens;
  digit_t data_sec_ones;
  logic   en;
  logic   running;
  logic   done;
  logic   err;

  modport master (
    output digit_valid, digit, startn, stopn, timer_zero,
    input  loadn, data_min, data_sec_tens, data_sec_ones,
           en, running, done, err
  );

  modport slave (
    input  digit_valid, digit, startn, stopn, timer_zero,
    output loadn, data_min, data_sec_tens, data_sec_ones,
           en, running, done, err
  );

endinterface

// File: rtl/timer_entry_ctrl_fall_edge_det.sv
// fall_edge_det: falling-edge event detector for an active-low button.
//   clk    - clock
//   clearn - asynchronous active-low reset
//   din    - raw active-low button level
//   fall   - one-cycle event, derived only from registered samples
// The sample registers reset to 1 (released). The armed flag keeps a button
// that is already held down when reset ends from producing an event: it only
// arms once the button has been seen released.
module fall_edge_det (
  input  logic clk,
  input  logic clearn,
  input  logic din,
  output logic fall
);

  logic in_reg;
  logic prev_reg;
  logic armed_reg;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      in_reg    <= 1'b1;
      prev_reg  <= 1'b1;
      armed_reg <= 1'b0;
    end else begin
      in_reg    <= din;
      prev_reg  <= in_reg;
      armed_reg <= armed_reg | din;
    end
  end

  assign fall = armed_reg & prev_reg & ~in_reg;

endmodule

// File: rtl/timer_entry_ctrl.sv
// timer_entry_ctrl: keypad entry and start/stop control for an mm:ss
// countdown built from external BCD counters.
//   clk         - clock, rising edge
//   clearn      - asynchronous active-low reset
//   bus (slave) - digit_valid/digit keypad strobe, startn/stopn buttons,
//                 timer_zero from the counters; loadn/data_* counter load,
//                 en countdown tick, running, done and err status pulses.
// All outputs are registered; data_* is the entry buffer itself.
module timer_entry_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input logic          clk,
  input logic          clearn,
  timer_entry_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t          state_reg, state_next;
  digit_t          bmin_reg, bmin_next;
  digit_t          btens_reg, btens_next;
  digit_t          bones_reg, bones_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic            loadn_reg, loadn_next;
  logic            en_reg, en_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic            running_reg, running_next;

  // Button event detection: index 0 = start, index 1 = stop.
  logic [1:0] btn_n;
  logic [1:0] btn_fall;
  logic       start_ev;
  logic       stop_ev;

  assign btn_n = {bus.stopn, bus.startn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    fall_edge_det u_det (
      .clk    (clk),
      .clearn (clearn),
      .din    (btn_n[gi]),
      .fall   (btn_fall[gi])
    );
  end

  assign start_ev = btn_fall[0];
  assign stop_ev  = btn_fall[1];

  logic digit_ok;
  logic buf_zero;

  assign digit_ok = bus.digit_valid && is_digit(bus.digit);
  assign buf_zero = (bmin_reg == 4'd0) && (btens_reg == 4'd0) && (bones_reg == 4'd0);

  always_comb begin
    state_next = state_reg;
    bmin_next  = bmin_reg;
    btens_next = btens_reg;
    bones_next = bones_reg;
    presc_next = presc_reg;
    loadn_next = 1'b1;
    en_next    = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (digit_ok) begin
          bmin_next  = btens_reg;
          btens_next = bones_reg;
          bones_next = bus.digit;
          state_next = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        // Stop beats start; any button event in this cycle swallows a key.
        if (stop_ev) begin
          bmin_next  = '0;
          btens_next = '0;
          bones_next = '0;
          state_next = ST_IDLE;
        end else if (start_ev) begin
          if (btens_reg > 4'd5) begin
            err_next = 1'b1;
          end else if (!buf_zero) begin
            loadn_next = 1'b0;
            presc_next = '0;
            state_next = ST_RUN;
          end
        end else if (digit_ok) begin
          bmin_next  = btens_reg;
          btens_next = bones_reg;
          bones_next = bus.digit;
        end
      end

      ST_RUN: begin
        // During the load cycle the counters still show their old value, so
        // a stale timer_zero must not end the run before it has begun.
        if (bus.timer_zero && loadn_reg) begin
          done_next  = 1'b1;
          bmin_next  = '0;
          btens_next = '0;
          bones_next = '0;
          state_next = ST_IDLE;
        end else if (stop_ev) begin
          state_next = ST_PAUSE;
        end else begin
          en_next    = (presc_reg == PRESC_LAST);
          presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
        end
      end

      ST_PAUSE: begin
        if (stop_ev) begin
          // Cancel: reload the counters with zero.
          bmin_next  = '0;
          btens_next = '0;
          bones_next = '0;
          loadn_next = 1'b0;
          state_next = ST_IDLE;
        end else if (start_ev) begin
          state_next = ST_RUN;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    running_next = (state_next == ST_RUN);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_reg   <= ST_IDLE;
      bmin_reg    <= '0;
      btens_reg   <= '0;
      bones_reg   <= '0;
      presc_reg   <= '0;
      loadn_reg   <= 1'b1;
      en_reg      <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bmin_reg    <= bmin_next;
      btens_reg   <= btens_next;
      bones_reg   <= bones_next;
      presc_reg   <= presc_next;
      loadn_reg   <= loadn_next;
      en_reg      <= en_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      running_reg <= running_next;
    end
  end

  assign bus.loadn         = loadn_reg;
  assign bus.data_min      = bmin_reg;
  assign bus.data_sec_tens = btens_reg;
  assign bus.data_sec_ones = bones_reg;
  assign bus.en            = en_reg;
  assign bus.done          = done_reg;
  assign bus.err           = err_reg;
  assign bus.running       = running_reg;

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Testbench for timer_entry_ctrl with TICK_DIV = 4. A behavioural model of the
// controller and a model of the downstream mm:ss counters run alongside the
// DUT; outputs are compared on every falling clock edge, plus literal checks
// for the directed scenarios, followed by randomized stimulus.
module tb_timer_entry_ctrl;
  import timer_pkg::*;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic clearn = 1'b0;
  always #5 clk = ~clk;

  timer_entry_if bus ();

  timer_entry_ctrl #(.TICK_DIV(TD)) dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: dut=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- downstream BCD counters ----------------
  int  c_min, c_tens, c_ones;
  bit  tz_force;

  always @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      c_min <= 0; c_tens <= 0; c_ones <= 0;
    end else if (!bus.loadn) begin
      c_min  <= int'(bus.data_min);
      c_tens <= int'(bus.data_sec_tens);
      c_ones <= int'(bus.data_sec_ones);
    end else if (bus.en && (c_min + c_tens + c_ones) != 0) begin
      if (c_ones > 0) c_ones <= c_ones - 1;
      else begin
        c_ones <= 9;
        if (c_tens > 0) c_tens <= c_tens - 1;
        else begin
          c_tens <= 5;
          c_min  <= c_min - 1;
        end
      end
    end
  end

  assign bus.timer_zero = ((c_min == 0) && (c_tens == 0) && (c_ones == 0)) || tz_force;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 entry, 2 run, 3 pause. m_buf[2]=min, [1]=tens, [0]=ones.
  int  m_mode, m_phase, nsamp;
  int  m_buf[3];
  bit  m_loadn, m_en, m_done, m_err;
  bit [1:0] st_h, sp_h;   // {older, newer} button samples

  always @(posedge clk or negedge clearn) begin : model
    int mode, ph;
    int b[3];
    bit ld, e, dn, er, evs, eve, dok;
    if (!clearn) begin
      m_mode <= 0; m_phase <= 0; m_buf <= '{0, 0, 0};
      m_loadn <= 1'b1; m_en <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      st_h <= 2'b11; sp_h <= 2'b11; nsamp <= 0;
    end else begin
      // An event is a released sample followed by a pressed one.
      evs = (nsamp >= 2) && (st_h == 2'b10);
      eve = (nsamp >= 2) && (sp_h == 2'b10);
      st_h <= {st_h[0], bus.startn};
      sp_h <= {sp_h[0], bus.stopn};
      if (nsamp < 2) nsamp <= nsamp + 1;
      mode = m_mode; ph = m_phase; b = m_buf;
      ld = 1'b1; e = 1'b0; dn = 1'b0; er = 1'b0;
      dok = bus.digit_valid && (bus.digit <= 4'd9);
      case (mode)
        0: if (dok) begin
             b[2] = b[1]; b[1] = b[0]; b[0] = int'(bus.digit); mode = 1;
           end
        1: if (eve) begin
             b = '{0, 0, 0}; mode = 0;
           end else if (evs) begin
             if (b[1] > 5) er = 1'b1;
             else if (b[0] + b[1] + b[2] != 0) begin ld = 1'b0; ph = 0; mode = 2; end
           end else if (dok) begin
             b[2] = b[1]; b[1] = b[0]; b[0] = int'(bus.digit);
           end
        2: if (bus.timer_zero && m_loadn) begin
             dn = 1'b1; b = '{0, 0, 0}; mode = 0;
           end else if (eve) begin
             mode = 3;
           end else begin
             e = (ph == TD - 1);
             ph = (ph + 1) % TD;
           end
        default: if (eve) begin
             b = '{0, 0, 0}; ld = 1'b0; mode = 0;
           end else if (evs) begin
             mode = 2;
           end
      endcase
      m_mode <= mode; m_phase <= ph; m_buf <= b;
      m_loadn <= ld; m_en <= e; m_done <= dn; m_err <= er;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("loadn", int'(bus.loadn), int'(m_loadn));
      check("en", int'(bus.en), int'(m_en));
      check("done", int'(bus.done), int'(m_done));
      check("err", int'(bus.err), int'(m_err));
      check("running", int'(bus.running), (m_mode == 2) ? 1 : 0);
      check("data", int'({bus.data_min, bus.data_sec_tens, bus.data_sec_ones}),
            m_buf[2] * 256 + m_buf[1] * 16 + m_buf[0]);
    end
  end

  // ---------------- pulse monitors ----------------
  int n_load = 0, n_en = 0, n_done = 0, n_err = 0;
  int ld_data = 0;

  always @(negedge clk) begin
    if (!bus.loadn) begin
      n_load++;
      ld_data = int'({bus.data_min, bus.data_sec_tens, bus.data_sec_ones});
    end
    if (bus.en) n_en++;
    if (bus.done) n_done++;
    if (bus.err) n_err++;
  end

  function automatic int dat();
    return int'({bus.data_min, bus.data_sec_tens, bus.data_sec_ones});
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic key(input int d);
    $display("txn %0t: key %0d", $time, d);
    bus.digit_valid = 1'b1;
    bus.digit = 4'(d);
    step();
    bus.digit_valid = 1'b0;
    step();
  endtask

  task automatic press(input bit s, input bit p);
    $display("txn %0t: press start=%0d stop=%0d", $time, s, p);
    if (s) bus.startn = 1'b0;
    if (p) bus.stopn = 1'b0;
    steps(3);
    bus.startn = 1'b1;
    bus.stopn = 1'b1;
    steps(2);
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.en) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_en timeout at %0t: en=0 required=1", $time);
    end
  endtask

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog at %0t: simulation did not finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    int l0, e0, d0, r0, cnt;
    bit ok;
    bus.digit_valid = 1'b0; bus.digit = 4'd0;
    bus.startn = 1'b1; bus.stopn = 1'b1; tz_force = 1'b0;
    chk_on = 1'b1;
    steps(3);
    check("reset_loadn", int'(bus.loadn), 1);
    check("reset_en", int'(bus.en), 0);
    check("reset_running", int'(bus.running), 0);
    check("reset_data", dat(), 0);
    clearn = 1'b1;
    steps(3);

    // Keys 1,3,0 then start: load 1:30 and count.
    key(1); key(3); key(0);
    check("entry_data", dat(), 'h130);
    l0 = n_load;
    press(1'b1, 1'b0);
    check("start_loads", n_load - l0, 1);
    check("start_load_data", ld_data, 'h130);
    check("start_running", int'(bus.running), 1);
    e0 = n_en;
    steps(16);
    check("en_every_4", n_en - e0, 4);

    // Pause at prescaler count 2, then resume.
    wait_en(ok);
    step();
    bus.stopn = 1'b0;
    steps(3);
    bus.stopn = 1'b1;
    e0 = n_en;
    steps(10);
    check("pause_no_en", n_en - e0, 0);
    check("pause_running", int'(bus.running), 0);
    bus.startn = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 2) bus.startn = 1'b1;
      if (bus.en) begin cnt = i; break; end
    end
    bus.startn = 1'b1;
    check("resume_first_en", cnt, 4);

    // timer_zero in the prescaler=3 cycle: done wins over the tick.
    wait_en(ok);
    steps(3);
    tz_force = 1'b1;
    d0 = n_done;
    step();
    tz_force = 1'b0;
    check("tz_en", int'(bus.en), 0);
    check("tz_done", int'(bus.done), 1);
    step();
    check("tz_done_once", n_done - d0, 1);
    check("tz_idle_running", int'(bus.running), 0);
    check("tz_idle_data", dat(), 0);

    // Keys 1,7,0 then start: rejected with err.
    key(1); key(7); key(0);
    l0 = n_load; r0 = n_err;
    press(1'b1, 1'b0);
    check("err_pulses", n_err - r0, 1);
    check("err_no_load", n_load - l0, 0);
    check("err_data_kept", dat(), 'h170);
    press(1'b0, 1'b1);
    check("entry_stop_clear", dat(), 0);
    check("entry_stop_no_load", n_load - l0, 0);

    // Start and stop together in ENTRY; invalid keys ignored.
    key(4); key(2);
    l0 = n_load;
    press(1'b1, 1'b1);
    check("both_no_load", n_load - l0, 0);
    check("both_clear", dat(), 0);
    key(12); key(15);
    check("bad_keys_ignored", dat(), 0);

    // Pause then cancel: zero load.
    key(2); key(5);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    l0 = n_load;
    press(1'b0, 1'b1);
    check("cancel_load", n_load - l0, 1);
    check("cancel_load_data", ld_data, 0);
    check("cancel_running", int'(bus.running), 0);

    // Asynchronous reset mid-run, then a start button held through release.
    key(5);
    press(1'b1, 1'b0);
    steps(3);
    clearn = 1'b0;
    #1;
    check("async_running", int'(bus.running), 0);
    check("async_loadn", int'(bus.loadn), 1);
    check("async_en", int'(bus.en), 0);
    check("async_data", dat(), 0);
    bus.startn = 1'b0;
    bus.digit_valid = 1'b1;
    bus.digit = 4'd5;
    step();
    l0 = n_load;
    clearn = 1'b1;
    step();
    bus.digit_valid = 1'b0;
    steps(5);
    check("held_no_event", n_load - l0, 0);
    check("held_entry_data", dat(), 'h005);
    bus.startn = 1'b1;
    steps(3);
    check("release_no_event", n_load - l0, 0);
    press(1'b1, 1'b0);
    check("repress_loads", n_load - l0, 1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);

    // Randomized stimulus against the model.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: key(int'($urandom_range(0, 15)));
        3: key(int'($urandom_range(0, 2)));
        4: press(1'b1, 1'b0);
        5: press(1'b0, 1'b1);
        6: press(1'b1, 1'b1);
        7: steps(int'($urandom_range(1, 40)));
        8: begin
          $display("txn %0t: timer_zero pulse", $time);
          tz_force = 1'b1; step(); tz_force = 1'b0; step();
        end
        default: begin
          if ($urandom_range(0, 5) == 0) begin
            $display("txn %0t: reset pulse", $time);
            clearn = 1'b0; steps(2); clearn = 1'b1; step();
          end else begin
            steps(int'($urandom_range(1, 8)));
          end
        end
      endcase
    end

    steps(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
